jtcop_objdma: RTL

JTCOP_OBJDMA -- requirements
Module: jtcop_objdma

---
 rtl/jtcop_pkg.sv | 16 +
 rtl/jtcop_objdma.sv | 119 +++++++++++
 2 files changed

// File: rtl/jtcop_pkg.sv
// Shared definitions for the object-RAM to object-buffer DMA engine.
// Holds the state encoding and the default object RAM word-address width.
package jtcop_pkg;

  localparam int AW_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT_BUS = 3'd2,
    ST_RD       = 3'd3,
    ST_WR       = 3'd4,
    ST_REL      = 3'd5
  } state_t;

endpackage

// File: rtl/jtcop_objdma.sv
// Frame-start object DMA: takes the 68000 bus, copies 2**AW words from object
// RAM into the object buffer at two clocks per word, then hands the bus back.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | bus owned by CPU, waiting for copy_req
// REQ       | BRn asserted, waiting for BGn
// WAIT_BUS  | granted, waiting for CPU to finish its cycle (ASn high)
// RD        | src_addr presented; RAM data arrives next clock
// WR        | src_dout written to buffer at the same word address
// REL       | BGACKn released, single-clock done pulse
module jtcop_objdma
  import jtcop_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          copy_req,
  input  logic          cpu_BGn,
  input  logic          cpu_ASn,
  output logic          cpu_BRn,
  output logic          cpu_BGACKn,
  output logic [AW-1:0] src_addr,
  input  logic [15:0]   src_dout,
  output logic [AW-1:0] buf_addr,
  output logic [15:0]   buf_din,
  output logic          buf_we,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] CNT_LAST = '1;
  localparam logic [AW-1:0] CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          brn_q, brn_d;
  logic          bgackn_q, bgackn_d;
  logic          we_q, we_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (copy_req) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (!cpu_BGn) state_d = ST_WAIT_BUS;
      end
      ST_WAIT_BUS: begin
        // a withdrawn grant sends us back to requesting, BRn stays low
        if (cpu_BGn) begin
          state_d = ST_REQ;
        end else if (cpu_ASn) begin
          state_d = ST_RD;
          cnt_d   = '0;
        end
      end
      ST_RD: begin
        state_d = ST_WR;
      end
      ST_WR: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_REL;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = ST_RD;
        end
      end
      ST_REL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // outputs are registered from the next state so they line up with it
    brn_d    = !((state_d == ST_REQ) || (state_d == ST_WAIT_BUS));
    bgackn_d = !((state_d == ST_RD) || (state_d == ST_WR));
    we_d     = (state_d == ST_WR);
    done_d   = (state_d == ST_REL);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      brn_q    <= 1'b1;
      bgackn_q <= 1'b1;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      brn_q    <= brn_d;
      bgackn_q <= bgackn_d;
      we_q     <= we_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign cpu_BRn    = brn_q;
  assign cpu_BGACKn = bgackn_q;
  assign src_addr   = cnt_q;
  assign buf_addr   = cnt_q;
  assign buf_din    = we_q ? src_dout : 16'h0000;
  assign buf_we     = we_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
